// File: rtl/key_event_pkg.sv
// Shared types for the keypad event classifier: event type codes, event record and FSM states.
package key_event_pkg;

  typedef enum logic [2:0] {
    EV_SINGLE = 3'd0,
    EV_LONG   = 3'd1,
    EV_DOUBLE = 3'd2,
    EV_CHORD  = 3'd3,
    EV_REPEAT = 3'd4
  } ev_type_e;

  localparam int KEY_W = 4;

  // Event record at the default key width; the classifier packs the same {type, key0, key1} layout.
  typedef struct packed {
    ev_type_e         ev_type;
    logic [KEY_W-1:0] key0;
    logic [KEY_W-1:0] key1;
  } key_event_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_WAIT_TAP,
    ST_HOLD,
    ST_FREEZE
  } kec_state_e;

endpackage

// File: rtl/key_event_fifo.sv
// Show-ahead event queue: head is visible whenever not empty, pop advances it.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];
  logic         wr_en;
  logic         rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rptr[AW-1:0]];

  // Storage is cleared on reset so the head reads as all-zero before the first event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr <= wptr + (AW+1)'(1);
      end
      if (rd_en) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/key_event_classifier.sv
// Keypad event classifier: turns key code + press flag into SINGLE/LONG/DOUBLE/CHORD/REPEAT events
// queued in a show-ahead FIFO. Define AUTO_REPEAT_EN to emit REPEAT events while a long press is held.
module key_event_classifier
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS      = 12,
  parameter int KW            = 4,
  parameter int TW            = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_PERIOD = 50,
  parameter int DW            = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [KW-1:0] key_val,
  input  logic          key_pressed,
  input  logic [TW-1:0] long_thresh,
  input  logic [TW-1:0] dtap_window,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [2:0]    ev_type,
  output logic [KW-1:0] ev_key0,
  output logic [KW-1:0] ev_key1,
  output logic          busy,
  output logic [DW-1:0] drop_cnt
);

  localparam int EW = 3 + 2*KW;
  localparam logic [KW-1:0] MAX_KEY = KW'(NUM_KEYS);

  kec_state_e    state;
  kec_state_e    state_d;
  logic          kp_q;
  logic [KW-1:0] k0;
  logic [TW-1:0] h;
  logic [TW-1:0] timer;
  logic          press_edge;
  logic          key_ok;
  logic          other_key;
  logic          load_k0;
  logic          push;
  ev_type_e      push_type;
  logic [KW-1:0] push_k1;
  logic [EW-1:0] head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          rep_hit;

  assign press_edge = key_pressed && !kp_q;
  assign key_ok     = (key_val != '0) && (key_val <= MAX_KEY);
  assign other_key  = key_pressed && (key_val != k0);

`ifdef AUTO_REPEAT_EN
  localparam int RPW = $clog2(REPEAT_PERIOD + 1);
  logic [RPW-1:0] rep_cnt;

  assign rep_hit = (rep_cnt == RPW'(REPEAT_PERIOD));

  // rep_cnt is 1 on the first HOLD cycle, so the first REPEAT lands REPEAT_PERIOD cycles after LONG.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    rep_cnt <= RPW'(1);
    else if (state != ST_HOLD)  rep_cnt <= RPW'(1);
    else if (rep_hit)           rep_cnt <= RPW'(1);
    else                        rep_cnt <= rep_cnt + RPW'(1);
  end
`else
  logic unused_repeat;
  assign rep_hit       = 1'b0;
  assign unused_repeat = ^REPEAT_PERIOD;
`endif

  // Event decode: the push is issued in the same cycle the deciding input is seen.
  always_comb begin
    state_d   = state;
    push      = 1'b0;
    push_type = EV_SINGLE;
    push_k1   = '0;
    load_k0   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (press_edge && key_ok) begin
          load_k0 = 1'b1;
          state_d = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (other_key) begin
          push      = 1'b1;
          push_type = EV_CHORD;
          push_k1   = key_val;
          state_d   = ST_FREEZE;
        end else if (key_pressed && (long_thresh != '0) && (h == long_thresh)) begin
          push      = 1'b1;
          push_type = EV_LONG;
          state_d   = ST_HOLD;
        end else if (!key_pressed) begin
          if (dtap_window == '0) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_TAP;
          end
        end
      end
      ST_WAIT_TAP: begin
        // On expiry a simultaneous fresh press starts a new classification rather than being lost.
        if (timer == dtap_window) begin
          push = 1'b1;
          if (press_edge && key_ok) begin
            load_k0 = 1'b1;
            state_d = ST_PRESS;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (press_edge && key_ok) begin
          push = 1'b1;
          if (key_val == k0) begin
            push_type = EV_DOUBLE;
            state_d   = ST_FREEZE;
          end else begin
            load_k0 = 1'b1;
            state_d = ST_PRESS;
          end
        end
      end
      ST_HOLD: begin
        if (!key_pressed) begin
          state_d = ST_IDLE;
        end else if (other_key) begin
          state_d = ST_FREEZE;
        end else if (rep_hit) begin
          push      = 1'b1;
          push_type = EV_REPEAT;
        end
      end
      ST_FREEZE: begin
        if (!key_pressed) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, timers and the saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      kp_q     <= 1'b0;
      k0       <= '0;
      h        <= '0;
      timer    <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_d;
      busy  <= (state_d != ST_IDLE);
      kp_q  <= key_pressed;
      if (load_k0) begin
        k0 <= key_val;
        h  <= TW'(1);
      end else if (((state == ST_PRESS) || (state == ST_HOLD)) && (h != '1)) begin
        h <= h + TW'(1);
      end
      if (state != ST_WAIT_TAP)  timer <= '0;
      else if (timer != '1)      timer <= timer + TW'(1);
      if (push && fifo_full && !pop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DW'(1);
    end
  end

  assign pop      = ev_valid && ev_ready;
  assign ev_valid = !fifo_empty;
  assign ev_type  = head[EW-1 -: 3];
  assign ev_key0  = head[2*KW-1 -: KW];
  assign ev_key1  = head[KW-1:0];

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({push_type, k0, push_k1}),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_key_event_classifier.sv
// Directed bench for key_event_classifier (long_thresh=10, dtap_window=5, depth 4, repeat period 3).
module tb_key_event_classifier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_val = '0;
  logic        key_pressed = 1'b0;
  logic [31:0] long_thresh = 32'd10;
  logic [31:0] dtap_window = 32'd5;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [2:0]  ev_type;
  logic [3:0]  ev_key0;
  logic [3:0]  ev_key1;
  logic        busy;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  key_event_classifier #(
    .NUM_KEYS      (12),
    .KW            (4),
    .TW            (32),
    .FIFO_DEPTH    (4),
    .REPEAT_PERIOD (3),
    .DW            (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_val     (key_val),
    .key_pressed (key_pressed),
    .long_thresh (long_thresh),
    .dtap_window (dtap_window),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_type     (ev_type),
    .ev_key0     (ev_key0),
    .ev_key1     (ev_key1),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({ev_valid, ev_type, ev_key0, ev_key1, busy, drop_cnt} !== 21'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {ev_valid, ev_type, ev_key0, ev_key1, busy, drop_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    key_val = 4'd13; key_pressed = 1'b1;
    tick(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_code13: busy got %b expected 0", busy);
    end
    key_pressed = 1'b0; key_val = 4'd0;
    tick(1);
    key_pressed = 1'b1;
    tick(2);
    checks++;
    if ({busy, ev_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL ignore_code0: busy/valid got %b expected 00", {busy, ev_valid});
    end
    key_pressed = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    key_val = 4'd3; key_pressed = 1'b1;
    tick(4);
    key_pressed = 1'b0; key_val = 4'd0;
    tick(6);
    checks++;
    if ({ev_valid, busy} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL single_before_window: valid/busy got %b expected 01", {ev_valid, busy});
    end
    tick(1);
    checks++;
    if ({ev_valid, ev_type, ev_key0, ev_key1, busy} !== {1'b1, 3'd0, 4'd3, 4'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL single_event: got %h expected %h", {ev_valid, ev_type, ev_key0, ev_key1, busy}, {1'b1, 3'd0, 4'd3, 4'd0, 1'b0});
    end
    tick(1);
    pop_one();
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_count: ev_valid got %b expected 0", ev_valid);
    end
  endtask

  task automatic test_single_no_window();
    dtap_window = 32'd0;
    key_val = 4'd3; key_pressed = 1'b1;
    tick(4);
    key_pressed = 1'b0; key_val = 4'd0;
    tick(1);
    checks++;
    if ({ev_valid, ev_type, ev_key0, ev_key1, busy} !== {1'b1, 3'd0, 4'd3, 4'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL single_nowindow: got %h expected %h", {ev_valid, ev_type, ev_key0, ev_key1, busy}, {1'b1, 3'd0, 4'd3, 4'd0, 1'b0});
    end
    pop_one();
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_nowindow_count: ev_valid got %b expected 0", ev_valid);
    end
    dtap_window = 32'd5;
  endtask

  task automatic test_long();
    key_val = 4'd1; key_pressed = 1'b1;
    tick(10);
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL long_early: ev_valid got %b expected 0", ev_valid);
    end
    tick(1);
    checks++;
    if ({ev_valid, ev_type, ev_key0, ev_key1, busy} !== {1'b1, 3'd1, 4'd1, 4'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL long_event: got %h expected %h", {ev_valid, ev_type, ev_key0, ev_key1, busy}, {1'b1, 3'd1, 4'd1, 4'd0, 1'b1});
    end
    tick(4);
    key_pressed = 1'b0; key_val = 4'd0;
    tick(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL long_release_idle: busy got %b expected 0", busy);
    end
    pop_one();
`ifdef AUTO_REPEAT_EN
    checks++;
    if ({ev_valid, ev_type, ev_key0, ev_key1} !== {1'b1, 3'd4, 4'd1, 4'd0}) begin
      errors++;
      $display("[TB] FAIL repeat_event: got %h expected %h", {ev_valid, ev_type, ev_key0, ev_key1}, {1'b1, 3'd4, 4'd1, 4'd0});
    end
    pop_one();
`endif
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL long_count: ev_valid got %b expected 0", ev_valid);
    end
  endtask

  task automatic test_double();
    key_val = 4'd5; key_pressed = 1'b1;
    tick(3);
    key_pressed = 1'b0; key_val = 4'd0;
    tick(2);
    checks++;
    if ({ev_valid, busy} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL double_gap: valid/busy got %b expected 01", {ev_valid, busy});
    end
    key_val = 4'd5; key_pressed = 1'b1;
    tick(1);
    checks++;
    if ({ev_valid, ev_type, ev_key0, ev_key1, busy} !== {1'b1, 3'd2, 4'd5, 4'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL double_event: got %h expected %h", {ev_valid, ev_type, ev_key0, ev_key1, busy}, {1'b1, 3'd2, 4'd5, 4'd0, 1'b1});
    end
    tick(2);
    key_pressed = 1'b0; key_val = 4'd0;
    tick(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL double_release_idle: busy got %b expected 0", busy);
    end
    pop_one();
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL double_count: ev_valid got %b expected 0", ev_valid);
    end
  endtask

  task automatic test_chord();
    key_val = 4'd9; key_pressed = 1'b1;
    tick(4);
    key_val = 4'd7;
    tick(1);
    checks++;
    if ({ev_valid, ev_type, ev_key0, ev_key1, busy} !== {1'b1, 3'd3, 4'd9, 4'd7, 1'b1}) begin
      errors++;
      $display("[TB] FAIL chord_event: got %h expected %h", {ev_valid, ev_type, ev_key0, ev_key1, busy}, {1'b1, 3'd3, 4'd9, 4'd7, 1'b1});
    end
    tick(10);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL chord_freeze: busy got %b expected 1", busy);
    end
    key_pressed = 1'b0; key_val = 4'd0;
    tick(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL chord_release_idle: busy got %b expected 0", busy);
    end
    pop_one();
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL chord_no_long: ev_valid got %b expected 0", ev_valid);
    end
  endtask

  task automatic test_overflow();
    dtap_window = 32'd0;
    for (int k = 1; k <= 5; k++) begin
      key_val = 4'(k); key_pressed = 1'b1;
      tick(1);
      key_pressed = 1'b0; key_val = 4'd0;
      tick(1);
    end
    checks++;
    if ({ev_valid, drop_cnt} !== {1'b1, 8'd1}) begin
      errors++;
      $display("[TB] FAIL overflow_drop: valid/drop got %h expected %h", {ev_valid, drop_cnt}, {1'b1, 8'd1});
    end
    ev_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if ({ev_valid, ev_type, ev_key0} !== {1'b1, 3'd0, 4'(i)}) begin
        errors++;
        $display("[TB] FAIL overflow_order%0d: got %h expected %h", i, {ev_valid, ev_type, ev_key0}, {1'b1, 3'd0, 4'(i)});
      end
      tick(1);
    end
    ev_ready = 1'b0;
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_drained: ev_valid got %b expected 0", ev_valid);
    end
    dtap_window = 32'd5;
  endtask

  task automatic test_reset_mid_press();
    key_val = 4'd2; key_pressed = 1'b1;
    tick(6);
    rst = 1'b1;
    #1;
    checks++;
    if ({ev_valid, ev_type, ev_key0, ev_key1, busy, drop_cnt} !== 21'h0) begin
      errors++;
      $display("[TB] FAIL midpress_reset: got %h expected 0", {ev_valid, ev_type, ev_key0, ev_key1, busy, drop_cnt});
    end
    tick(1);
    key_pressed = 1'b0; key_val = 4'd0;
    tick(1);
    rst = 1'b0;
    tick(12);
    checks++;
    if ({ev_valid, busy, drop_cnt} !== 10'h0) begin
      errors++;
      $display("[TB] FAIL midpress_no_event: got %h expected 0", {ev_valid, busy, drop_cnt});
    end
  endtask

  task automatic test_back_to_back();
    dtap_window = 32'd0;
    for (int k = 6; k <= 10; k++) begin
      key_val = 4'(k); key_pressed = 1'b1;
      tick(1);
      key_pressed = 1'b0; key_val = 4'd0;
      if (k == 10) ev_ready = 1'b1;
      tick(1);
      ev_ready = 1'b0;
    end
    checks++;
    if ({ev_valid, ev_key0, drop_cnt} !== {1'b1, 4'd7, 8'd0}) begin
      errors++;
      $display("[TB] FAIL full_push_pop: valid/key0/drop got %h expected %h", {ev_valid, ev_key0, drop_cnt}, {1'b1, 4'd7, 8'd0});
    end
    ev_ready = 1'b1;
    for (int i = 7; i <= 10; i++) begin
      checks++;
      if ({ev_valid, ev_type, ev_key0} !== {1'b1, 3'd0, 4'(i)}) begin
        errors++;
        $display("[TB] FAIL b2b_order%0d: got %h expected %h", i, {ev_valid, ev_type, ev_key0}, {1'b1, 3'd0, 4'(i)});
      end
      tick(1);
    end
    ev_ready = 1'b0;
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_drained: ev_valid got %b expected 0", ev_valid);
    end
    dtap_window = 32'd5;
  endtask

  initial begin
    $display("[TB] key_event_classifier directed tests");
    test_reset();
    test_single();
    test_single_no_window();
    test_long();
    test_double();
    test_chord();
    test_overflow();
    test_reset_mid_press();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
